// File: rtl/imm_encoder.sv
// Instruction-word builder for RV64 load/store/branch: scatters a range-checked
// immediate into I/S/SB positions and queues finished words in a small FIFO.
module imm_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_fmt,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [2:0]                 in_funct3,
  input  logic [63:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [7:0]                 err_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          rangeOk;
  logic [11:0]   imm12;
  logic [31:0]   instr;
  logic          push;
  logic          pop;

  logic [32:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    err_count_q, err_count_d;

  // The immediate must be a sign-extended 12-bit value; otherwise its bits are zeroed.
  always_comb begin
    rangeOk = (&in_imm[63:11]) | ~(|in_imm[63:11]);
    imm12   = rangeOk ? in_imm[11:0] : 12'd0;
    case (in_fmt)
      2'b00:   instr = {imm12, in_rs1, in_funct3, in_rd, 7'b0000011};
      2'b01:   instr = {imm12[11:5], in_rs2, in_rs1, in_funct3, imm12[4:0], 7'b0100011};
      default: instr = {imm12[11], imm12[9:4], in_rs2, in_rs1, in_funct3,
                        imm12[3:0], imm12[10], 7'b1100011};
    endcase
  end

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_count_d = err_count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (!rangeOk && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_count_q <= err_count_d;
    end
  end

  // Storage is not reset; a handshake coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= {~rangeOk, instr};
  end

  assign out_instr = mem_q[rd_ptr_q][31:0];
  assign out_err   = mem_q[rd_ptr_q][32];
  assign count     = count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: constant vectors, corner sequences and a
// scoreboard that decodes every emitted word back to its immediate.
module tb_imm_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [2:0]  count;
  logic [7:0]  err_count;

  imm_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .count(count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [63:0] imm;
    logic        hasExp;
    logic [31:0] expInstr;
    logic        expErr;
  } req_t;

  req_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  int   acceptCnt = 0;
  int   expErrCnt = 0;
  logic monEn = 1'b0;
  logic        curHasExp = 1'b0;
  logic [31:0] curExpInstr = '0;
  logic        curExpErr = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decode the immediate back out of a word, choosing the layout from bits [6:5].
  function automatic logic [63:0] extractImm(input logic [31:0] w);
    case (w[6:5])
      2'b00:   return {{52{w[31]}}, w[31:20]};
      2'b01:   return {{52{w[31]}}, w[31:25], w[11:7]};
      2'b11:   return {{52{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
      default: return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  task automatic checkEntry(input req_t e);
    longint v;
    logic   isErr;
    logic [6:0] op;
    v     = e.imm;
    isErr = (v < -2048) || (v > 2047);
    op    = (e.fmt == 2'b00) ? 7'h03 : (e.fmt == 2'b01) ? 7'h23 : 7'h63;
    checkOutput("err_flag", out_err, isErr);
    checkOutput("imm_roundtrip", extractImm(out_instr), isErr ? 64'd0 : e.imm);
    checkOutput("opcode", out_instr[6:0], op);
    checkOutput("rs1", out_instr[19:15], e.rs1);
    checkOutput("funct3", out_instr[14:12], e.f3);
    if (e.fmt == 2'b00) checkOutput("rd", out_instr[11:7], e.rd);
    else                checkOutput("rs2", out_instr[24:20], e.rs2);
    if (e.hasExp) begin
      checkOutput("vec_instr", out_instr, e.expInstr);
      checkOutput("vec_err", out_err, e.expErr);
    end
  endtask

  // Scoreboard: occupancy and error count follow the model each cycle; pops compare, pushes enqueue.
  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("count", count, sbQ.size());
      checkOutput("err_count", err_count, expErrCnt);
      if (reset) begin
        sbQ.delete();
        expErrCnt = 0;
      end else begin
        if (out_valid && out_ready) begin
          if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_pop: got out_valid=1, expected empty queue");
          end else begin
            checkEntry(sbQ.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          req_t e;
          longint v;
          e.fmt = in_fmt; e.rd = in_rd; e.rs1 = in_rs1; e.rs2 = in_rs2;
          e.f3 = in_funct3; e.imm = in_imm;
          e.hasExp = curHasExp; e.expInstr = curExpInstr; e.expErr = curExpErr;
          sbQ.push_back(e);
          acceptCnt++;
          v = in_imm;
          if (((v < -2048) || (v > 2047)) && expErrCnt < 255) expErrCnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] fmt, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [63:0] imm, input logic hasExp,
                               input logic [31:0] expInstr, input logic expErr);
    in_valid = v; in_fmt = fmt; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_imm = imm;
    curHasExp = hasExp; curExpInstr = expInstr; curExpErr = expErr;
  endtask

  req_t vecs [9];

  initial begin
    int target;
    int r;
    logic [11:0] s;
    logic [63:0] imm;

    vecs[0] = '{2'b00, 5'd5,  5'd2,  5'd31, 3'd3, -64'sd8,    1'b1, 32'hFF813283, 1'b0};
    vecs[1] = '{2'b01, 5'd31, 5'd10, 5'd7,  3'd3, 64'd40,     1'b1, 32'h02753423, 1'b0};
    vecs[2] = '{2'b11, 5'd0,  5'd1,  5'd2,  3'd0, -64'sd2,    1'b1, 32'hFE208EE3, 1'b0};
    vecs[3] = '{2'b10, 5'd0,  5'd1,  5'd2,  3'd0, -64'sd2,    1'b1, 32'hFE208EE3, 1'b0};
    vecs[4] = '{2'b00, 5'd1,  5'd0,  5'd0,  3'd0, 64'd2048,   1'b1, 32'h00000083, 1'b1};
    vecs[5] = '{2'b00, 5'd1,  5'd0,  5'd0,  3'd0, -64'sd2048, 1'b1, 32'h80000083, 1'b0};
    vecs[6] = '{2'b01, 5'd0,  5'd4,  5'd3,  3'd2, 64'd2047,   1'b1, 32'h7E322FA3, 1'b0};
    vecs[7] = '{2'b10, 5'd0,  5'd0,  5'd0,  3'd1, -64'sd2048, 1'b1, 32'h80001063, 1'b0};
    vecs[8] = '{2'b01, 5'd0,  5'd1,  5'd1,  3'd0, -64'sd2049, 1'b1, 32'h00108023, 1'b1};

    reset = 1'b1;
    out_ready = 1'b0;
    applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
    tick();
    monEn = 1'b1;
    tick();
    reset = 1'b0;

    // Single load: head becomes valid exactly one edge after acceptance.
    applyStimulus(1'b1, 2'b00, 5'd5, 5'd2, 5'd0, 3'd3, -64'sd8, 1'b1, 32'hFF813283, 1'b0);
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_out_valid", out_valid, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("latency_out_valid", out_valid, 1'b1);
    checkOutput("latency_instr", out_instr, 32'hFF813283);
    tick();
    out_ready = 1'b1;
    tick();
    tick();

    // Table vectors back to back with the consumer always ready.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, vecs[i].fmt, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3,
                    vecs[i].imm, 1'b1, vecs[i].expInstr, vecs[i].expErr);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checkOutput("table_err_count", err_count, 8'd2);
    checkOutput("table_drained", out_valid, 1'b0);

    // Error counter saturates at 255.
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b1, 2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 64'h1000, 1'b1, 32'h00000083, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checkOutput("err_count_saturated", err_count, 8'd255);

    // Backpressure: fill, hold a fifth request, then stream with wrap-around.
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'b01, 5'd0, 5'(i + 1), 5'(i + 8), 3'(i), 64'(i * 8), 1'b0, '0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 2'b00, 5'd9, 5'd4, 5'd0, 3'd5, 64'd100, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("full_count", count, 3'd4);
    checkOutput("full_in_ready", in_ready, 1'b0);
    checkOutput("full_out_valid", out_valid, 1'b1);
    tick();
    @(negedge clk);
    checkOutput("full_held_count", count, 3'd4);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("first_pop_count", count, 3'd3);
    checkOutput("first_pop_in_ready", in_ready, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'(i % 3), 5'(i), 5'(i + 3), 5'(31 - i), 3'(i), -64'(i * 5), 1'b0, '0, 1'b0);
      @(negedge clk);
      checkOutput("stream_count", count, 3'd3);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && count != 0; i++) tick();
    @(negedge clk);
    checkOutput("stream_drained", count, 3'd0);

    // Reset with three entries queued and a handshake in the reset cycle.
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b00, 5'd1, 5'd2, 5'd0, 3'd0, 64'(i), 1'b0, '0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 64'h4000, 1'b0, '0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("pre_reset_count", count, 3'd3);
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_count", count, 3'd0);
    checkOutput("post_reset_out_valid", out_valid, 1'b0);
    checkOutput("post_reset_in_ready", in_ready, 1'b1);
    checkOutput("post_reset_err_count", err_count, 8'd0);
    applyStimulus(1'b1, 2'b10, 5'd0, 5'd1, 5'd2, 3'd0, -64'sd2, 1'b1, 32'hFE208EE3, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_push_valid", out_valid, 1'b1);
    checkOutput("post_reset_push_instr", out_instr, 32'hFE208EE3);
    tick();
    out_ready = 1'b1;
    tick();
    tick();

    // Random round trip with random backpressure.
    target = acceptCnt + 10000;
    for (int cyc = 0; cyc < 40000 && acceptCnt < target; cyc++) begin
      r = $urandom_range(0, 9);
      s = 12'($urandom);
      if (r < 7)      imm = {{52{s[11]}}, s};
      else if (r < 8) begin
        case ($urandom_range(0, 3))
          0:       imm = 64'd2047;
          1:       imm = -64'sd2048;
          2:       imm = 64'd2048;
          default: imm = -64'sd2049;
        endcase
      end else        imm = {$urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom), 5'($urandom), 5'($urandom),
                    5'($urandom), 3'($urandom), imm, 1'b0, '0, 1'b0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && count != 0; i++) tick();
    @(negedge clk);
    checkOutput("random_accepts", 64'(acceptCnt), 64'(target));
    checkOutput("random_drained", count, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
